spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
- Receive-side counterpart to the spiking neuron: converts a spike train back into an 8-bit rate value.
- Counts spike rising edges over a fixed window of WINDOW clock cycles and presents the count on a valid/ready output port.
- Sits downstream of a neuron's spike output. Drives uo_out/uio_out or feeds the next layer's input current.

Parameters:
- WINDOW, 256, window length in clock cycles; legal range 2..65535.
- WIN_W, 16, width of the window counter; must satisfy 2^WIN_W >= WINDOW.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  1  high = accumulate windows; low = idle
- spike_in  input  1  spike level from neuron
- rate  output  8  spike count of last completed window, saturated at 255
- rate_valid  output  1  rate holds an unconsumed result
- rate_ready  input  1  consumer accepts rate when rate_valid & rate_ready
- rate_sat  output  1  the result on rate saturated (more than 255 edges)
- overflow  output  1  sticky: a result was overwritten before it was accepted

Behaviour:
- Reset (async, active-high) clears all state:
  - rate=0, rate_valid=0, rate_sat=0, overflow=0.
  - Window counter = 0, edge counter = 0, spike_prev = 0, state = IDLE.
- Edge detect:
  - edge = spike_in & ~spike_prev; spike_prev is registered every cycle.
  - A pulse held high for N cycles counts once.
- States: IDLE and ACCUM.
  - IDLE -> ACCUM on enable=1. The first ACCUM cycle is window cycle 0.
  - ACCUM -> IDLE on enable=0. The partial window is discarded; window and edge counters clear to 0.
  - A pending rate/rate_valid is unaffected by leaving ACCUM.
- ACCUM, each cycle:
  - Window counter increments.
  - The edge counter increments on edge and saturates at 255; an internal sat bit is set if an edge arrives while the count is already 255.
- Window end (window counter == WINDOW-1):
  - An edge in this cycle belongs to the current window.
  - Next cycle: rate = final count, rate_sat = sat bit, rate_valid = 1.
  - Window counter, edge counter and sat bit restart at 0 the same cycle. Windows are back-to-back with no gap.
- Latency: result is visible 1 cycle after the last window cycle.
- Handshake:
  - rate, rate_sat are stable while rate_valid=1 and not accepted.
  - Transfer happens on a cycle with rate_valid & rate_ready; rate_valid drops next cycle unless a new result loads that same cycle, in which case rate_valid stays 1 with the new data.
- New result while rate_valid=1 and no transfer that cycle: the new result overwrites rate and overflow is set to 1. Overflow clears only on reset.
- rate_ready is ignored while rate_valid=0.

Optional Feature:
- Macro: SPIKE_DECODER_ISI_EN.
- Defined:
  - Adds output isi [WIN_W-1:0]: cycle distance between the last two edges inside the completed window.
  - isi = 0 if the window had fewer than 2 edges.
  - Loaded together with rate under the same valid/ready rules. Reset value 0.
- Undefined: no isi port, no interval counter logic.

Test Plan:
- WINDOW=16, enable=1, 1-cycle spike every 4 cycles starting window cycle 0 -> rate_valid rises on cycle 16, rate=4, rate_sat=0. With rate_ready=1, a new result every 16 cycles.
- WINDOW=16, spike_in held high for cycles 2..11 -> rate=1.
- WINDOW=600, spike toggling every cycle (300 edges) -> rate=255, rate_sat=1.
- WINDOW=16, rate_ready=0 across two windows with 3 then 5 spikes -> after the second window rate=5, overflow=1. Raise rate_ready -> rate_valid drops next cycle; overflow stays 1.
- Assert reset mid-window with rate_valid=1 -> all outputs 0 immediately (async). After release with enable=1, the first result arrives 17 cycles later and counts only post-reset edges. Separately, drop enable mid-window -> no result for the partial window.
- ISI_EN defined, WINDOW=32, spikes at window cycles 3, 10, 25 -> rate=3, isi=15. A single spike -> isi=0.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spike rising edges per WINDOW-cycle window into a valid/ready rate output.
// Define SPIKE_DECODER_ISI_EN to add the isi output (distance between the last two edges in a window).
module spike_rate_decoder #(
  parameter int WINDOW = 256,
  parameter int WIN_W  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       spike_in,
  output logic [7:0] rate,
  output logic       rate_valid,
  input  logic       rate_ready,
  output logic       rate_sat,
  output logic       overflow
`ifdef SPIKE_DECODER_ISI_EN
  ,
  output logic [WIN_W-1:0] isi
`endif
);
  typedef enum logic {IDLE, ACCUM} state_t;
  localparam logic [WIN_W-1:0] LAST = WIN_W'(WINDOW - 1);
  state_t state, state_nx;
  logic spike_prev, spike_edge, run, win_end, sat, sat_nx;
  logic [WIN_W-1:0] win_cnt;
  logic [7:0] edge_cnt, cnt_nx;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = enable ? ACCUM : IDLE;
  // dropping enable in ACCUM discards the window, including that very cycle
  always_comb begin
    run     = (state == ACCUM) && enable;
    win_end = run && (win_cnt == LAST);
  end
  always_comb begin
    spike_edge = spike_in & ~spike_prev;
    cnt_nx     = (spike_edge && edge_cnt != 8'hff) ? edge_cnt + 8'd1 : edge_cnt;
    sat_nx     = sat | (spike_edge & (edge_cnt == 8'hff));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      spike_prev <= 1'b0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
    end else begin
      spike_prev <= spike_in;
      win_cnt    <= (run && !win_end) ? win_cnt + 1'b1 : '0;
      edge_cnt   <= (run && !win_end) ? cnt_nx : '0;
      sat        <= run && !win_end && sat_nx;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rate       <= '0;
      rate_sat   <= 1'b0;
      rate_valid <= 1'b0;
      overflow   <= 1'b0;
    end else if (win_end) begin
      rate       <= cnt_nx;
      rate_sat   <= sat_nx;
      rate_valid <= 1'b1;
      if (rate_valid && !rate_ready) overflow <= 1'b1;
    end else if (rate_valid && rate_ready) begin
      rate_valid <= 1'b0;
    end
`ifdef SPIKE_DECODER_ISI_EN
  logic [WIN_W-1:0] last_pos, isi_cur, isi_nx;
  // edge_cnt != 0 means an earlier edge exists in this window, so last_pos is valid
  always_comb isi_nx = (spike_edge && edge_cnt != 8'd0) ? win_cnt - last_pos : isi_cur;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      last_pos <= '0;
      isi_cur  <= '0;
      isi      <= '0;
    end else begin
      last_pos <= (run && spike_edge) ? win_cnt : last_pos;
      isi_cur  <= (run && !win_end) ? isi_nx : '0;
      if (win_end) isi <= isi_nx;
    end
`endif
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: scoreboard bench for spike_rate_decoder (WINDOW 16, 600 and 32 instances).
module tb_spike_rate_decoder;
  logic clk = 1'b0;
  logic reset, enable, en_b, en_c, spike_in, rate_ready;
  logic [7:0] rate_a, rate_b, rate_c;
  logic valid_a, valid_b, valid_c, sat_a, sat_b, sat_c, ovf_a, ovf_b, ovf_c;
`ifdef SPIKE_DECODER_ISI_EN
  logic [15:0] isi_a, isi_b, isi_c;
`endif
  int total = 0;
  int bad = 0;
  int q[$];
  int exp;

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW(16)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
    .rate(rate_a), .rate_valid(valid_a), .rate_ready(rate_ready),
    .rate_sat(sat_a), .overflow(ovf_a)
`ifdef SPIKE_DECODER_ISI_EN
    , .isi(isi_a)
`endif
  );
  spike_rate_decoder #(.WINDOW(600)) dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .spike_in(spike_in),
    .rate(rate_b), .rate_valid(valid_b), .rate_ready(rate_ready),
    .rate_sat(sat_b), .overflow(ovf_b)
`ifdef SPIKE_DECODER_ISI_EN
    , .isi(isi_b)
`endif
  );
  spike_rate_decoder #(.WINDOW(32)) dut_c (
    .clk(clk), .reset(reset), .enable(en_c), .spike_in(spike_in),
    .rate(rate_c), .rate_valid(valid_c), .rate_ready(rate_ready),
    .rate_sat(sat_c), .overflow(ovf_c)
`ifdef SPIKE_DECODER_ISI_EN
    , .isi(isi_c)
`endif
  );

  function automatic logic pat(input int m, input int c);
    case (m)
      0: return c % 4 == 0;
      1: return c >= 2 && c <= 11;
      2: return c == 0 || c == 4 || c == 8;
      3: return c <= 8 && c % 2 == 0;
      4: return c == 0 || c == 5 || c == 10;
      5: return c % 2 == 0;
      6: return c % 2 == 0 && c < 510;
      7: return c == 3 || c == 10 || c == 25;
      8: return c == 7;
      default: return 1'b0;
    endcase
  endfunction

  // window cycle c of the pattern is presented across one rising edge
  task automatic drive(input int from, input int to, input int m);
    for (int c = from; c < to; c++) begin
      spike_in = pat(m, c);
      @(negedge clk);
    end
    spike_in = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; en_b = 1'b0; en_c = 1'b0;
    spike_in = 1'b0; rate_ready = 1'b0;
    #1;
    total++; if (rate_a !== 8'd0) begin bad++; $display("FAIL reset_rate got=%0d exp=0", rate_a); end
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
    total++; if (sat_a !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", sat_a); end
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf_a); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rate;
    rate_ready = 1'b1; enable = 1'b1;
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      q.push_back(4);
      drive(0, 15, 0);
      if (w == 0) begin
        total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL rate_early_valid got=%b exp=0", valid_a); end
      end
      drive(15, 16, 0);
      exp = q.pop_front();
      total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL rate_valid w%0d got=%b exp=1", w, valid_a); end
      total++; if (rate_a !== 8'(exp)) begin bad++; $display("FAIL rate w%0d got=%0d exp=%0d", w, rate_a, exp); end
      total++; if (sat_a !== 1'b0) begin bad++; $display("FAIL rate_sat w%0d got=%b exp=0", w, sat_a); end
    end
    enable = 1'b0;
    @(negedge clk);
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL rate_accept got=%b exp=0", valid_a); end
  endtask

  task automatic test_held;
    enable = 1'b1;
    @(negedge clk);
    q.push_back(1);
    drive(0, 16, 1);
    exp = q.pop_front();
    total++; if (valid_a !== 1'b1 || rate_a !== 8'(exp)) begin bad++; $display("FAIL held got=%b/%0d exp=1/%0d", valid_a, rate_a, exp); end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    rate_ready = 1'b0; enable = 1'b1;
    @(negedge clk);
    q.push_back(1);
    drive(0, 16, 8);
    exp = q.pop_front();
    total++; if (valid_a !== 1'b1 || rate_a !== 8'(exp)) begin bad++; $display("FAIL b2b_first got=%b/%0d exp=1/%0d", valid_a, rate_a, exp); end
    q.push_back(3);
    drive(0, 15, 4);
    rate_ready = 1'b1;
    drive(15, 16, 4);
    exp = q.pop_front();
    total++; if (valid_a !== 1'b1 || rate_a !== 8'(exp)) begin bad++; $display("FAIL b2b_second got=%b/%0d exp=1/%0d", valid_a, rate_a, exp); end
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%b exp=0", ovf_a); end
    enable = 1'b0;
    @(negedge clk);
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%b exp=0", valid_a); end
  endtask

  task automatic test_overflow;
    rate_ready = 1'b0; enable = 1'b1;
    @(negedge clk);
    q.push_back(3);
    drive(0, 16, 2);
    exp = q.pop_front();
    total++; if (rate_a !== 8'(exp) || ovf_a !== 1'b0) begin bad++; $display("FAIL ovf_first got=%0d/%b exp=%0d/0", rate_a, ovf_a, exp); end
    q.push_back(5);
    drive(0, 16, 3);
    exp = q.pop_front();
    total++; if (rate_a !== 8'(exp) || valid_a !== 1'b1) begin bad++; $display("FAIL ovf_rate got=%0d/%b exp=%0d/1", rate_a, valid_a, exp); end
    total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf_a); end
    enable = 1'b0; rate_ready = 1'b1;
    @(negedge clk);
    total++; if (valid_a !== 1'b0 || ovf_a !== 1'b1) begin bad++; $display("FAIL ovf_accept got=%b/%b exp=0/1", valid_a, ovf_a); end
  endtask

  task automatic test_reset_mid;
    rate_ready = 1'b0; enable = 1'b1;
    @(negedge clk);
    drive(0, 16, 2);
    drive(0, 5, 0);
    #2 reset = 1'b1;
    #1;
    total++; if (rate_a !== 8'd0 || valid_a !== 1'b0 || sat_a !== 1'b0 || ovf_a !== 1'b0)
      begin bad++; $display("FAIL async_reset got=%0d/%b/%b/%b exp=0/0/0/0", rate_a, valid_a, sat_a, ovf_a); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    q.push_back(3);
    drive(0, 15, 4);
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL post_reset_early got=%b exp=0", valid_a); end
    drive(15, 16, 4);
    exp = q.pop_front();
    total++; if (valid_a !== 1'b1 || rate_a !== 8'(exp)) begin bad++; $display("FAIL post_reset got=%b/%0d exp=1/%0d", valid_a, rate_a, exp); end
    rate_ready = 1'b1; enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_enable_drop;
    rate_ready = 1'b0; enable = 1'b1;
    @(negedge clk);
    drive(0, 8, 0);
    enable = 1'b0;
    drive(8, 30, 0);
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL partial_window got=%b exp=0", valid_a); end
    enable = 1'b1;
    @(negedge clk);
    q.push_back(1);
    drive(0, 15, 8);
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL reenable_early got=%b exp=0", valid_a); end
    drive(15, 16, 8);
    exp = q.pop_front();
    total++; if (valid_a !== 1'b1 || rate_a !== 8'(exp)) begin bad++; $display("FAIL reenable got=%b/%0d exp=1/%0d", valid_a, rate_a, exp); end
    rate_ready = 1'b1; enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturation;
    rate_ready = 1'b1; en_b = 1'b1;
    @(negedge clk);
    q.push_back(255);
    drive(0, 600, 5);
    exp = q.pop_front();
    total++; if (valid_b !== 1'b1 || rate_b !== 8'(exp)) begin bad++; $display("FAIL sat_rate got=%b/%0d exp=1/%0d", valid_b, rate_b, exp); end
    total++; if (sat_b !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b exp=1", sat_b); end
    q.push_back(255);
    drive(0, 600, 6);
    exp = q.pop_front();
    total++; if (valid_b !== 1'b1 || rate_b !== 8'(exp)) begin bad++; $display("FAIL exact255_rate got=%b/%0d exp=1/%0d", valid_b, rate_b, exp); end
    total++; if (sat_b !== 1'b0) begin bad++; $display("FAIL exact255_sat got=%b exp=0", sat_b); end
    en_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_isi;
    rate_ready = 1'b1; en_c = 1'b1;
    @(negedge clk);
    q.push_back(3);
    drive(0, 32, 7);
    exp = q.pop_front();
    total++; if (valid_c !== 1'b1 || rate_c !== 8'(exp)) begin bad++; $display("FAIL isi_rate got=%b/%0d exp=1/%0d", valid_c, rate_c, exp); end
`ifdef SPIKE_DECODER_ISI_EN
    total++; if (isi_c !== 16'd15) begin bad++; $display("FAIL isi got=%0d exp=15", isi_c); end
`endif
    q.push_back(1);
    drive(0, 32, 8);
    exp = q.pop_front();
    total++; if (valid_c !== 1'b1 || rate_c !== 8'(exp)) begin bad++; $display("FAIL isi_single_rate got=%b/%0d exp=1/%0d", valid_c, rate_c, exp); end
`ifdef SPIKE_DECODER_ISI_EN
    total++; if (isi_c !== 16'd0) begin bad++; $display("FAIL isi_single got=%0d exp=0", isi_c); end
`endif
    en_c = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_rate;
    test_held;
    test_back_to_back;
    test_overflow;
    test_reset_mid;
    test_enable_drop;
    test_saturation;
    test_isi;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
